float2fxp_stream: RTL and testbench

//  Streaming, back-pressurable float->fixed converter for a generic IEEE-754-style input format.

---
 rtl/float2fxp_pkg.sv | 28 ++
 rtl/float2fxp_stream_unpack.sv | 53 +++++
 rtl/float2fxp_stream.sv | 267 ++++++++++++++++++++++++++
 tb/tb_float2fxp_stream.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/float2fxp_pkg.sv
// float2fxp_pkg
//   Shared types and helpers for the float2fxp_stream converter.
//   - fp_class_t : classification of an input float (zero/denormal, normal,
//                  infinity, not-a-number)
//   - sat_limits : largest and smallest two's complement value of a given width
package float2fxp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  typedef struct packed {
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
  } sat_lim_t;

  // Saturation bounds of a w-bit two's complement number (w <= 63).
  function automatic sat_lim_t sat_limits(input int w);
    sat_lim_t lim;
    lim.max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    lim.min_v = -(64'sd1 <<< (w - 1));
    return lim;
  endfunction

endpackage

// File: rtl/float2fxp_stream_unpack.sv
// float_unpack
//   Combinational first-stage logic of float2fxp_stream: splits an
//   IEEE-754-style word into its fields, removes the exponent bias and
//   classifies the value. Denormals are reported as ZERO (flushed).
// Ports
//   in_data  in   1+WEI+WEF   {sign, exponent, fraction}
//   sign     out  1           sign bit
//   cls      out  fp_class_t  ZERO / NORM / INF / NAN
//   exp_ub   out  WEI+2       unbiased exponent, signed
//   mant     out  WEF+1       mantissa with the hidden one restored
module float_unpack
  import float2fxp_pkg::*;
#(
  parameter int WEI = 8,
  parameter int WEF = 23
) (
  input  logic [WEI+WEF:0]      in_data,
  output logic                  sign,
  output fp_class_t             cls,
  output logic signed [WEI+1:0] exp_ub,
  output logic [WEF:0]          mant
);

  localparam int EW = WEI + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((2 ** (WEI - 1)) - 1);

  logic [WEI-1:0] exp_f;
  logic [WEF-1:0] frac_f;

  assign sign   = in_data[WEI+WEF];
  assign exp_f  = in_data[WEI+WEF-1:WEF];
  assign frac_f = in_data[WEF-1:0];
  assign mant   = {1'b1, frac_f};
  // Two zero bits on top keep the biased exponent positive before subtraction.
  assign exp_ub = $signed({2'b00, exp_f}) - BIAS;

  // Classify on the raw exponent field.
  always_comb begin
    cls = NORM;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == '1) begin
      if (frac_f == '0) begin
        cls = INF;
      end else begin
        cls = NAN;
      end
    end else begin
      cls = NORM;
    end
  end

endmodule

// File: rtl/float2fxp_stream.sv
// float2fxp_stream
//   Streaming float -> two's complement fixed-point converter with a
//   valid/ready handshake on both sides and a user sideband carried with
//   each sample. Three pipeline stages:
//     S1 unpack/classify, S2 align shift, S3 round/negate/saturate.
//   Latency 3 cycles, throughput 1 sample/cycle, bubbles collapse.
//   Optional feature macro: FLOAT2FXP_OVF_CNT_EN adds ovf_cnt/cnt_clr and a
//   saturating count of overflowing output handshakes.
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data, in_user     {sign, exponent, fraction} and sideband tag
//   out_valid/out_ready  output handshake
//   out_data, out_user   W-bit fixed-point result and its tag
//   overflow             result was saturated (qualified by out_valid)
//   ovf_cnt, cnt_clr     overflow counter and its synchronous clear (macro only)
module float2fxp_stream
  import float2fxp_pkg::*;
#(
  parameter int WEI   = 8,
  parameter int WEF   = 23,
  parameter int WOI   = 10,
  parameter int WOF   = 10,
  parameter int ROUND = 1,
  parameter int WU    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WEI+WEF:0]     in_data,
  input  logic [WU-1:0]        in_user,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out_data,
  output logic [WU-1:0]        out_user,
  output logic                 overflow
`ifdef FLOAT2FXP_OVF_CNT_EN
  ,
  output logic [15:0]          ovf_cnt,
  input  logic                 cnt_clr
`endif
);

  localparam int W    = WOI + WOF;
  localparam int EW   = WEI + 2;
  // Width of the mantissa pre-shifted left by W; the align step only shifts right.
  localparam int BW   = WEF + 1 + W;
  localparam int SHW  = $clog2(BW);
  // Right-shift amount is TOFF - unbiased exponent (see S2 comment).
  localparam int TOFF = WOI - 1 + WEF;

  localparam sat_lim_t      LIM     = sat_limits(W);
  localparam logic [W-1:0]  SAT_MAX = LIM.max_v[W-1:0];
  localparam logic [W-1:0]  SAT_MIN = LIM.min_v[W-1:0];
  // Largest magnitudes representable for positive and negative results.
  localparam logic [W:0]    MAG_POS = {1'b0, SAT_MAX};
  localparam logic [W:0]    MAG_NEG = {1'b0, SAT_MIN};

  // ---------------- handshake ----------------
  logic s1_valid_r, s2_valid_r, out_valid_r;
  logic s1_ready_s, s2_ready_s, s3_ready_s;

  assign s3_ready_s = !out_valid_r || out_ready;
  assign s2_ready_s = !s2_valid_r  || s3_ready_s;
  assign s1_ready_s = !s1_valid_r  || s2_ready_s;
  assign in_ready   = s1_ready_s;

  // ---------------- S1: unpack/classify ----------------
  logic                 u_sign_s;
  fp_class_t            u_cls_s;
  logic signed [EW-1:0] u_exp_s;
  logic [WEF:0]         u_mant_s;

  float_unpack #(
    .WEI (WEI),
    .WEF (WEF)
  ) u_unpack (
    .in_data (in_data),
    .sign    (u_sign_s),
    .cls     (u_cls_s),
    .exp_ub  (u_exp_s),
    .mant    (u_mant_s)
  );

  logic                 s1_sign_r;
  fp_class_t            s1_cls_r;
  logic signed [EW-1:0] s1_exp_r;
  logic [WEF:0]         s1_mant_r;
  logic [WU-1:0]        s1_user_r;

  // Stage 1 register: capture the unpacked fields of an accepted sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_cls_r   <= ZERO;
      s1_exp_r   <= '0;
      s1_mant_r  <= '0;
      s1_user_r  <= '0;
    end else if (s1_ready_s) begin
      s1_valid_r <= in_valid;
      s1_sign_r  <= u_sign_s;
      s1_cls_r   <= u_cls_s;
      s1_exp_r   <= u_exp_s;
      s1_mant_r  <= u_mant_s;
      s1_user_r  <= in_user;
    end
  end

  // ---------------- S2: align shift ----------------
  // mag2 = floor(|value| * 2^(WOF+1)): the magnitude with one extra
  // fraction bit, which is all round-half-away-from-zero needs.
  // mag2 = (mant << W) >> t with t = WOI-1+WEF-e. t < WEF means
  // |value| >= 2^WOI, which saturates for either sign ("big").
  int          t_s;
  logic        big_s;
  logic [W:0]  mag2_s;
  logic [BW-1:0] base_s;

  // Align the mantissa to the output grid, flagging out-of-range exponents.
  always_comb begin
    t_s    = TOFF - int'(s1_exp_r);
    base_s = {s1_mant_r, {W{1'b0}}};
    big_s  = 1'b0;
    mag2_s = '0;
    if (s1_cls_r == NORM) begin
      if (t_s < WEF) begin
        big_s = 1'b1;
      end else if (t_s < BW) begin
        mag2_s = (W+1)'(base_s >> t_s[SHW-1:0]);
      end else begin
        // Everything shifts out: tiny value, magnitude rounds to zero.
        mag2_s = '0;
      end
    end else begin
      big_s  = 1'b0;
      mag2_s = '0;
    end
  end

  logic          s2_sign_r;
  fp_class_t     s2_cls_r;
  logic          s2_big_r;
  logic [W:0]    s2_mag2_r;
  logic [WU-1:0] s2_user_r;

  // Stage 2 register: aligned magnitude plus class/sign/tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_cls_r   <= ZERO;
      s2_big_r   <= 1'b0;
      s2_mag2_r  <= '0;
      s2_user_r  <= '0;
    end else if (s2_ready_s) begin
      s2_valid_r <= s1_valid_r;
      s2_sign_r  <= s1_sign_r;
      s2_cls_r   <= s1_cls_r;
      s2_big_r   <= big_s;
      s2_mag2_r  <= mag2_s;
      s2_user_r  <= s1_user_r;
    end
  end

  // ---------------- S3: round/negate/saturate ----------------
  logic [W:0]   mag_s;
  logic [W-1:0] res_s;
  logic         ovf_s;

  // Round the magnitude, apply the sign and clamp to the output range.
  always_comb begin
    if (ROUND != 0) begin
      mag_s = {1'b0, s2_mag2_r[W:1]} + {{W{1'b0}}, s2_mag2_r[0]};
    end else begin
      mag_s = {1'b0, s2_mag2_r[W:1]};
    end
    res_s = '0;
    ovf_s = 1'b0;
    case (s2_cls_r)
      ZERO: begin
        res_s = '0;
        ovf_s = 1'b0;
      end
      INF: begin
        res_s = s2_sign_r ? SAT_MIN : SAT_MAX;
        ovf_s = 1'b1;
      end
      NAN: begin
        res_s = SAT_MAX;
        ovf_s = 1'b1;
      end
      NORM: begin
        if (s2_big_r) begin
          res_s = s2_sign_r ? SAT_MIN : SAT_MAX;
          ovf_s = 1'b1;
        end else if (!s2_sign_r) begin
          if (mag_s > MAG_POS) begin
            res_s = SAT_MAX;
            ovf_s = 1'b1;
          end else begin
            res_s = mag_s[W-1:0];
            ovf_s = 1'b0;
          end
        end else begin
          // Magnitude 2^(W-1) negates to exactly the minimum, which is legal.
          if (mag_s > MAG_NEG) begin
            res_s = SAT_MIN;
            ovf_s = 1'b1;
          end else begin
            res_s = (~mag_s[W-1:0]) + {{(W-1){1'b0}}, 1'b1};
            ovf_s = 1'b0;
          end
        end
      end
      default: begin
        res_s = '0;
        ovf_s = 1'b0;
      end
    endcase
  end

  logic [W-1:0]  out_data_r;
  logic [WU-1:0] out_user_r;
  logic          overflow_r;

  // Output register: loads only when empty or handing over, so it holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_user_r  <= '0;
      overflow_r  <= 1'b0;
    end else if (s3_ready_s) begin
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        out_data_r <= res_s;
        out_user_r <= s2_user_r;
        overflow_r <= ovf_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_user  = out_user_r;
  assign overflow  = overflow_r;

`ifdef FLOAT2FXP_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;

  // Count overflowing output handshakes, sticking at all-ones; clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      ovf_cnt_r <= 16'd0;
    end else if (out_valid_r && out_ready && overflow_r && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_float2fxp_stream.sv
// Self-checking bench for float2fxp_stream (default parameters:
// float32 in, Q10.10 out, round half away from zero).
module tb_float2fxp_stream;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [3:0]  in_user = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic [3:0]  out_user;
  logic        overflow;
`ifdef FLOAT2FXP_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  logic        cnt_clr = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // expected {user, overflow, data} in output order
  logic [24:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [25:0] held = 26'd0;

  always #5 clk = ~clk;

  float2fxp_stream dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_user   (in_user),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_user  (out_user),
    .overflow  (overflow)
`ifdef FLOAT2FXP_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: real-valued conversion, x*1024 rounded half away from zero, clamped.
  function automatic logic [20:0] ref_conv(input logic [31:0] f);
    int  e;
    real mag;
    real r;
    longint q;
    logic [63:0] qb;
    e = int'(f[30:23]);
    if (e == 0) return {1'b0, 20'd0};
    if (e == 255) begin
      if (f[22:0] == 23'd0 && f[31]) return {1'b1, 20'h80000};
      return {1'b1, 20'h7FFFF};
    end
    mag = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** real'(e - 127)) * 1024.0;
    r = $floor(mag + 0.5);
    if (!f[31] && r > 524287.0) return {1'b1, 20'h7FFFF};
    if (f[31] && r > 524288.0) return {1'b1, 20'h80000};
    q = longint'(r);
    if (f[31]) q = -q;
    qb = 64'(q);
    return {1'b0, qb[19:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] f;
    int k;
    k = $urandom_range(0, 15);
    f = $urandom;
    if (k == 0) f[30:23] = 8'd0;
    else if (k == 1) f[30:23] = 8'hFF;
    else if (k < 5) f[30:23] = 8'(134 + $urandom_range(0, 3));
    else f[30:23] = 8'($urandom_range(105, 137));
    return f;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (stall_prev) check_val("stall_hold", {out_valid, out_user, overflow, out_data}, held);
      if (out_valid && out_ready) begin
        check_val("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_val("out_sample", {out_user, overflow, out_data}, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back({in_user, ref_conv(in_data)});
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_user, overflow, out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // One sample into an empty pipe; checks latency and the given expected result.
  task automatic lat_test(input logic [31:0] d, input logic [3:0] u, input string tag,
                          input logic [19:0] exp_d, input logic exp_o);
    int cyc;
    in_data = d; in_user = u; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, "_lat"}, 64'(cyc), 64'd3);
    check_val({tag, "_data"}, 64'(out_data), 64'(exp_d));
    check_val({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
  endtask

  task automatic run_burst(input int n, input bit toggle);
    int sent;
    int cyc;
    logic acc;
    sent = 0; cyc = 0;
    in_data = rand_float(); in_user = 4'(sent);
    while ((sent < n || exp_q.size() != 0) && cyc < 4000) begin
      in_valid = (sent < n) && (toggle || ($urandom_range(0, 3) != 0));
      out_ready = toggle ? ~cyc[0] : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_data = rand_float();
        in_user = 4'(sent);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_val("burst_bound", 64'(cyc < 4000), 64'd1);
    check_val("burst_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_out_user", 64'(out_user), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    lat_test(32'hc36f0d77, 4'd1, "v0", 20'(-244790), 1'b0);
    lat_test(32'hc19d957c, 4'd2, "v1", 20'(-20171), 1'b0);
    lat_test(32'h4341cd28, 4'd3, "v2", 20'(198453), 1'b0);
    lat_test(32'h44696e31, 4'd4, "big", 20'h7FFFF, 1'b1);
    lat_test(32'h7f800000, 4'd5, "pinf", 20'h7FFFF, 1'b1);
    lat_test(32'h7fc00000, 4'd6, "nan", 20'h7FFFF, 1'b1);
    lat_test(32'hff800000, 4'd7, "ninf", 20'h80000, 1'b1);
    lat_test(32'hc4000000, 4'd8, "m512", 20'h80000, 1'b0);
    lat_test(32'h00000000, 4'd9, "pz", 20'd0, 1'b0);
    lat_test(32'h80000000, 4'd10, "nz", 20'd0, 1'b0);
    lat_test(32'h00000001, 4'd11, "denorm", 20'd0, 1'b0);
    lat_test(32'h3ac00000, 4'd12, "tie_p", 20'd2, 1'b0);
    lat_test(32'hbac00000, 4'd13, "tie_n", 20'(-2), 1'b0);
    lat_test(32'h43ffffff, 4'd14, "rnd_ovf", 20'h7FFFF, 1'b1);
    lat_test(32'hc3ffffff, 4'd15, "rnd_min", 20'h80000, 1'b0);

    run_burst(8, 1'b1);
    run_burst(300, 1'b0);

    // Fill all three stages with the output stalled, then reset mid-stream.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rand_float(); in_user = 4'(8 + i);
      @(negedge clk);
      check_val("fill_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_data = 32'h3f800000;
    @(negedge clk);
    check_val("full_in_ready", 64'(in_ready), 64'd0);
    check_val("full_out_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_out_data", 64'(out_data), 64'd0);
    check_val("arst_overflow", 64'(overflow), 64'd0);
    check_val("arst_out_user", 64'(out_user), 64'd0);
    check_val("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
`ifdef FLOAT2FXP_OVF_CNT_EN
    check_val("cnt_reset", 64'(ovf_cnt), 64'd0);
`endif
    lat_test(32'h40000000, 4'd5, "post_rst", 20'd2048, 1'b0);

`ifdef FLOAT2FXP_OVF_CNT_EN
    for (int i = 0; i < 5; i++) lat_test(32'h7f800000, 4'(i), "cnt_ovf", 20'h7FFFF, 1'b1);
    @(posedge clk); #1;
    check_val("cnt_five", 64'(ovf_cnt), 64'd5);
    lat_test(32'hff800000, 4'd6, "cnt_sixth", 20'h80000, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check_val("cnt_clr_prio", 64'(ovf_cnt), 64'd0);
`endif

    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check_val("end_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
